// File: rtl/int_pkg.sv
// Shared encodings for the interrupt/reset sequencer: request kinds,
// fixed vector addresses and sequencer states.
package int_pkg;

    typedef enum logic [1:0] {
        KIND_NONE = 2'b00,
        KIND_IRQ  = 2'b01,
        KIND_NMI  = 2'b10,
        KIND_RST  = 2'b11
    } kind_t;

    localparam logic [15:0] VEC_NMI = 16'hFFFA;
    localparam logic [15:0] VEC_RST = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ = 16'hFFFE;

    typedef enum logic [1:0] {
        S_RST = 2'd0,
        IDLE  = 2'd1,
        LOCK  = 2'd2
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with a registered level
// output and an optional rising-edge strobe derived from that level.
module sync_edge #(
    parameter int STAGES = 2,
    parameter bit EDGE   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign level_o = sync_q[STAGES-1];

    generate
        if (EDGE) begin : g_edge
            logic prev_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    prev_q <= 1'b0;
                end else begin
                    prev_q <= level_o;
                end
            end

            assign rise_o = level_o & ~prev_q;
        end else begin : g_no_edge
            assign rise_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/int_ctl.sv
// Interrupt and reset sequencer: synchronises, masks and prioritises RST, NMI
// and NIRQ level IRQs, and holds one locked request until ctl acks the vector.
module int_ctl
    import int_pkg::*;
#(
    parameter int          NIRQ        = 8,
    parameter int          SYNC_STAGES = 2,
    parameter int          VECTORED    = 0,
    parameter logic [15:0] IRQ_BASE    = 16'hFFE0,
    localparam int         SRC_W       = (NIRQ > 1) ? $clog2(NIRQ) : 1
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [NIRQ-1:0]  irq,
    input  logic             nmi,
    input  logic             I,
    input  logic             sync,
    input  logic             ack,
    input  logic             mask_we,
    input  logic [NIRQ-1:0]  mask_di,
    output logic             req,
    output logic [1:0]       kind,
    output logic [SRC_W-1:0] src,
    output logic [15:0]      vec,
    output logic [NIRQ-1:0]  mask_do,
    output logic [NIRQ-1:0]  pending,
    output state_t           dbg_state
);

    // Lowest-numbered set channel wins.
    function automatic logic [SRC_W-1:0] lowest_set(input logic [NIRQ-1:0] v);
        lowest_set = '0;
        for (int k = NIRQ - 1; k >= 0; k--) begin
            if (v[k]) lowest_set = SRC_W'(k);
        end
    endfunction

    logic [NIRQ-1:0]  irq_s;
    logic [NIRQ-1:0]  irq_rise_unused;
    logic             nmi_lvl_unused;
    logic             nmi_rise;

    state_t           state_q, state_d;
    logic             req_q, req_d;
    kind_t            kind_q, kind_d;
    logic [SRC_W-1:0] src_q, src_d;
    logic [15:0]      vec_q, vec_d;
    logic [NIRQ-1:0]  mask_q, mask_d;
    logic             nmi_pend_q, nmi_pend_d;
    logic             rst_pend_q, rst_pend_d;

    logic             irq_ok;
    logic             ack_lock;
    logic [SRC_W-1:0] win;
    logic [15:0]      irq_vec;

    genvar k;
    generate
        for (k = 0; k < NIRQ; k++) begin : g_irq_sync
            sync_edge #(.STAGES(SYNC_STAGES), .EDGE(1'b0)) u_sync (
                .clk     (clk),
                .rst     (RST),
                .d_i     (irq[k]),
                .level_o (irq_s[k]),
                .rise_o  (irq_rise_unused[k])
            );
        end
    endgenerate

    sync_edge #(.STAGES(SYNC_STAGES), .EDGE(1'b1)) u_nmi_sync (
        .clk     (clk),
        .rst     (RST),
        .d_i     (nmi),
        .level_o (nmi_lvl_unused),
        .rise_o  (nmi_rise)
    );

    assign pending  = irq_s & mask_q;
    assign irq_ok   = (|pending) & ~I;
    assign win      = lowest_set(pending);
    assign irq_vec  = (VECTORED != 0) ? (IRQ_BASE + 16'({win, 1'b0})) : VEC_IRQ;
    assign ack_lock = ack && (state_q == LOCK);

    // A fresh NMI edge beats a simultaneous ack-clear so no edge is lost.
    always_comb begin
        mask_d     = mask_we ? mask_di : mask_q;
        nmi_pend_d = nmi_rise | (nmi_pend_q & ~(ack_lock && kind_q == KIND_NMI));
        rst_pend_d = rst_pend_q & ~(ack_lock && kind_q == KIND_RST);
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        kind_d  = kind_q;
        src_d   = src_q;
        vec_d   = vec_q;
        case (state_q)
            S_RST: begin
                state_d = LOCK;
                req_d   = 1'b1;
                kind_d  = KIND_RST;
                src_d   = '0;
                vec_d   = VEC_RST;
            end
            IDLE: begin
                if (sync && (rst_pend_q || nmi_pend_q || irq_ok)) begin
                    state_d = LOCK;
                    req_d   = 1'b1;
                    if (rst_pend_q) begin
                        kind_d = KIND_RST;
                        src_d  = '0;
                        vec_d  = VEC_RST;
                    end else if (nmi_pend_q) begin
                        kind_d = KIND_NMI;
                        src_d  = '0;
                        vec_d  = VEC_NMI;
                    end else begin
                        kind_d = KIND_IRQ;
                        src_d  = win;
                        vec_d  = irq_vec;
                    end
                end
            end
            LOCK: begin
                if (ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    kind_d  = KIND_NONE;
                    src_d   = '0;
                    vec_d   = '0;
                end
            end
            default: state_d = S_RST;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q    <= S_RST;
            req_q      <= 1'b0;
            kind_q     <= KIND_NONE;
            src_q      <= '0;
            vec_q      <= '0;
            mask_q     <= '1;
            nmi_pend_q <= 1'b0;
            rst_pend_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            kind_q     <= kind_d;
            src_q      <= src_d;
            vec_q      <= vec_d;
            mask_q     <= mask_d;
            nmi_pend_q <= nmi_pend_d;
            rst_pend_q <= rst_pend_d;
        end
    end

    assign req       = req_q;
    assign kind      = kind_q;
    assign src       = src_q;
    assign vec       = vec_q;
    assign mask_do   = mask_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_int_ctl.sv
// Directed bench for int_ctl: a vectored instance plus a flat-vector twin
// sharing every input, checked against hand-computed values.
module tb_int_ctl;
    import int_pkg::*;

    logic        clk = 1'b0;
    logic        RST;
    logic [7:0]  irq;
    logic        nmi, I, sync, ack, mask_we;
    logic [7:0]  mask_di;

    logic        req, req_f;
    logic [1:0]  kind, kind_f;
    logic [2:0]  src, src_f;
    logic [15:0] vec, vec_f;
    logic [7:0]  mask_do, mask_do_f, pending, pending_f;
    state_t      dbg, dbg_f;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    int_ctl #(.NIRQ(8), .SYNC_STAGES(2), .VECTORED(1), .IRQ_BASE(16'hFFE0)) dut (
        .clk(clk), .RST(RST), .irq(irq), .nmi(nmi), .I(I), .sync(sync), .ack(ack),
        .mask_we(mask_we), .mask_di(mask_di), .req(req), .kind(kind), .src(src),
        .vec(vec), .mask_do(mask_do), .pending(pending), .dbg_state(dbg)
    );

    int_ctl #(.NIRQ(8), .SYNC_STAGES(2), .VECTORED(0), .IRQ_BASE(16'hFFE0)) u_flat (
        .clk(clk), .RST(RST), .irq(irq), .nmi(nmi), .I(I), .sync(sync), .ack(ack),
        .mask_we(mask_we), .mask_di(mask_di), .req(req_f), .kind(kind_f), .src(src_f),
        .vec(vec_f), .mask_do(mask_do_f), .pending(pending_f), .dbg_state(dbg_f)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_sync();
        sync = 1'b1;
        tick();
        sync = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0; irq = '1; nmi = 0; I = 0; sync = 0; ack = 0; mask_we = 0; mask_di = '0;
        #1 RST = 1'b1;
        tick(3);
        total_cnt++; if ({req, kind, src, vec} !== 22'h0) $display("FAIL reset_outs: got %h exp %h", {req, kind, src, vec}, 22'h0); else pass_cnt++;
        total_cnt++; if ({mask_do, pending} !== 16'hFF00) $display("FAIL reset_mask_pend: got %h exp %h", {mask_do, pending}, 16'hFF00); else pass_cnt++;
        total_cnt++; if (dbg !== S_RST) $display("FAIL reset_state: got %0d exp %0d", dbg, S_RST); else pass_cnt++;
        irq = '0; RST = 1'b0;
        tick();
        total_cnt++; if ({req, kind, src, vec} !== {1'b1, 2'b11, 3'd0, 16'hFFFC}) $display("FAIL rst_lock: got %h exp %h", {req, kind, src, vec}, {1'b1, 2'b11, 3'd0, 16'hFFFC}); else pass_cnt++;
        total_cnt++; if (dbg !== LOCK) $display("FAIL rst_lock_state: got %0d exp %0d", dbg, LOCK); else pass_cnt++;
        pulse_ack();
        total_cnt++; if ({req, kind} !== 3'b000) $display("FAIL rst_ack: got %b exp %b", {req, kind}, 3'b000); else pass_cnt++;
        total_cnt++; if (dbg !== IDLE) $display("FAIL rst_ack_state: got %0d exp %0d", dbg, IDLE); else pass_cnt++;
        pulse_sync();
        total_cnt++; if (req !== 1'b0) $display("FAIL idle_sync_noreq: got %b exp %b", req, 1'b0); else pass_cnt++;
    endtask

    task automatic test_irq_priority();
        I = 0;
        irq = 8'b0010_0100;
        tick();
        total_cnt++; if (pending !== 8'h00) $display("FAIL irq_sync_latency: got %h exp %h", pending, 8'h00); else pass_cnt++;
        tick();
        total_cnt++; if (pending !== 8'h24) $display("FAIL irq_pending: got %h exp %h", pending, 8'h24); else pass_cnt++;
        pulse_sync();
        total_cnt++; if ({req, kind, src, vec} !== {1'b1, 2'b01, 3'd2, 16'hFFE4}) $display("FAIL irq_lock_ch2: got %h exp %h", {req, kind, src, vec}, {1'b1, 2'b01, 3'd2, 16'hFFE4}); else pass_cnt++;
        total_cnt++; if (vec_f !== 16'hFFFE) $display("FAIL irq_flat_vec: got %h exp %h", vec_f, 16'hFFFE); else pass_cnt++;
        pulse_sync();
        total_cnt++; if ({req, kind, src, vec} !== {1'b1, 2'b01, 3'd2, 16'hFFE4}) $display("FAIL lock_ignores_sync: got %h exp %h", {req, kind, src, vec}, {1'b1, 2'b01, 3'd2, 16'hFFE4}); else pass_cnt++;
        pulse_ack();
        total_cnt++; if ({req, kind} !== 3'b000) $display("FAIL irq_ack: got %b exp %b", {req, kind}, 3'b000); else pass_cnt++;
        irq = 8'b0010_0000;
        tick(2);
        pulse_sync();
        total_cnt++; if ({req, kind, src, vec} !== {1'b1, 2'b01, 3'd5, 16'hFFEA}) $display("FAIL irq_lock_ch5: got %h exp %h", {req, kind, src, vec}, {1'b1, 2'b01, 3'd5, 16'hFFEA}); else pass_cnt++;
        pulse_ack();
        irq = '0;
        tick(2);
    endtask

    task automatic test_mask_and_i();
        mask_we = 1; mask_di = 8'hFB;
        tick();
        mask_we = 0;
        total_cnt++; if (mask_do !== 8'hFB) $display("FAIL mask_load: got %h exp %h", mask_do, 8'hFB); else pass_cnt++;
        irq = 8'h04;
        tick(2);
        total_cnt++; if (pending !== 8'h00) $display("FAIL masked_pending: got %h exp %h", pending, 8'h00); else pass_cnt++;
        pulse_sync();
        total_cnt++; if (req !== 1'b0) $display("FAIL masked_noreq: got %b exp %b", req, 1'b0); else pass_cnt++;
        I = 1; mask_we = 1; mask_di = 8'hFF;
        tick();
        mask_we = 0;
        total_cnt++; if (pending !== 8'h04) $display("FAIL unmask_pending: got %h exp %h", pending, 8'h04); else pass_cnt++;
        pulse_sync();
        total_cnt++; if (req !== 1'b0) $display("FAIL iflag_noreq: got %b exp %b", req, 1'b0); else pass_cnt++;
        I = 0;
        pulse_sync();
        total_cnt++; if ({req, kind, src, vec} !== {1'b1, 2'b01, 3'd2, 16'hFFE4}) $display("FAIL iclear_lock: got %h exp %h", {req, kind, src, vec}, {1'b1, 2'b01, 3'd2, 16'hFFE4}); else pass_cnt++;
        irq = '0; I = 1; mask_we = 1; mask_di = 8'h00;
        tick();
        mask_we = 0;
        pulse_sync();
        tick(2);
        total_cnt++; if ({req, kind, src, vec} !== {1'b1, 2'b01, 3'd2, 16'hFFE4}) $display("FAIL lock_frozen: got %h exp %h", {req, kind, src, vec}, {1'b1, 2'b01, 3'd2, 16'hFFE4}); else pass_cnt++;
        total_cnt++; if (pending !== 8'h00) $display("FAIL lock_mask_pending: got %h exp %h", pending, 8'h00); else pass_cnt++;
        I = 0; mask_we = 1; mask_di = 8'hFF;
        pulse_ack();
        mask_we = 0;
        total_cnt++; if ({req, kind} !== 3'b000) $display("FAIL frozen_ack: got %b exp %b", {req, kind}, 3'b000); else pass_cnt++;
    endtask

    task automatic test_nmi_during_lock();
        irq = 8'h01;
        tick(2);
        pulse_sync();
        total_cnt++; if ({req, kind, src, vec} !== {1'b1, 2'b01, 3'd0, 16'hFFE0}) $display("FAIL irq0_lock: got %h exp %h", {req, kind, src, vec}, {1'b1, 2'b01, 3'd0, 16'hFFE0}); else pass_cnt++;
        irq = '0; nmi = 1;
        tick();
        nmi = 0;
        tick(4);
        pulse_sync();
        total_cnt++; if ({req, kind, src, vec} !== {1'b1, 2'b01, 3'd0, 16'hFFE0}) $display("FAIL nmi_in_lock: got %h exp %h", {req, kind, src, vec}, {1'b1, 2'b01, 3'd0, 16'hFFE0}); else pass_cnt++;
        total_cnt++; if (vec_f !== 16'hFFFE) $display("FAIL nmi_in_lock_flat: got %h exp %h", vec_f, 16'hFFFE); else pass_cnt++;
        pulse_ack();
        total_cnt++; if (req !== 1'b0) $display("FAIL irq0_ack: got %b exp %b", req, 1'b0); else pass_cnt++;
        pulse_sync();
        total_cnt++; if ({req, kind, src, vec} !== {1'b1, 2'b10, 3'd0, 16'hFFFA}) $display("FAIL nmi_lock: got %h exp %h", {req, kind, src, vec}, {1'b1, 2'b10, 3'd0, 16'hFFFA}); else pass_cnt++;
        total_cnt++; if (vec_f !== 16'hFFFA) $display("FAIL nmi_lock_flat: got %h exp %h", vec_f, 16'hFFFA); else pass_cnt++;
        pulse_ack();
        nmi = 1;
        tick(4);
        pulse_sync();
        total_cnt++; if ({req, kind, src, vec} !== {1'b1, 2'b10, 3'd0, 16'hFFFA}) $display("FAIL nmi_held_lock: got %h exp %h", {req, kind, src, vec}, {1'b1, 2'b10, 3'd0, 16'hFFFA}); else pass_cnt++;
        pulse_ack();
        tick(3);
        pulse_sync();
        total_cnt++; if (req !== 1'b0) $display("FAIL nmi_held_once: got %b exp %b", req, 1'b0); else pass_cnt++;
        nmi = 0;
        tick(3);
    endtask

    task automatic test_simultaneous();
        nmi = 1;
        tick(4);
        nmi = 0;
        tick(3);
        pulse_sync();
        total_cnt++; if ({req, kind, vec} !== {1'b1, 2'b10, 16'hFFFA}) $display("FAIL simul_first_lock: got %h exp %h", {req, kind, vec}, {1'b1, 2'b10, 16'hFFFA}); else pass_cnt++;
        nmi = 1;
        tick(2);
        ack = 1;
        tick();
        ack = 0;
        total_cnt++; if ({req, kind} !== 3'b000) $display("FAIL simul_ack: got %b exp %b", {req, kind}, 3'b000); else pass_cnt++;
        pulse_sync();
        total_cnt++; if ({req, kind, vec} !== {1'b1, 2'b10, 16'hFFFA}) $display("FAIL simul_relock: got %h exp %h", {req, kind, vec}, {1'b1, 2'b10, 16'hFFFA}); else pass_cnt++;
        pulse_ack();
        nmi = 0;
        tick(3);
        pulse_sync();
        total_cnt++; if (req !== 1'b0) $display("FAIL simul_cleared: got %b exp %b", req, 1'b0); else pass_cnt++;
    endtask

    task automatic test_reset_mid_lock();
        mask_we = 1; mask_di = 8'h0F;
        tick();
        mask_we = 0;
        nmi = 1;
        tick(4);
        nmi = 0;
        tick(3);
        pulse_sync();
        total_cnt++; if ({req, kind} !== 3'b110) $display("FAIL midrst_nmi_lock: got %b exp %b", {req, kind}, 3'b110); else pass_cnt++;
        #2 RST = 1;
        #1;
        total_cnt++; if ({req, kind, src, vec} !== 22'h0) $display("FAIL midrst_outs: got %h exp %h", {req, kind, src, vec}, 22'h0); else pass_cnt++;
        total_cnt++; if (mask_do !== 8'hFF) $display("FAIL midrst_mask: got %h exp %h", mask_do, 8'hFF); else pass_cnt++;
        total_cnt++; if (dbg !== S_RST) $display("FAIL midrst_state: got %0d exp %0d", dbg, S_RST); else pass_cnt++;
        tick();
        RST = 0;
        tick();
        total_cnt++; if ({req, kind, src, vec} !== {1'b1, 2'b11, 3'd0, 16'hFFFC}) $display("FAIL midrst_release: got %h exp %h", {req, kind, src, vec}, {1'b1, 2'b11, 3'd0, 16'hFFFC}); else pass_cnt++;
        pulse_ack();
        total_cnt++; if (req !== 1'b0) $display("FAIL midrst_ack: got %b exp %b", req, 1'b0); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_irq_priority();
        test_mask_and_i();
        test_nmi_during_lock();
        test_simultaneous();
        test_reset_mid_lock();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
